// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state encoding and default PRBS-7 constants,
// also used by the pattern generator.
package prbs_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int unsigned PRBS7_WIDTH  = 7;
  localparam int unsigned PRBS7_TAP    = 6;
  localparam int unsigned PRBS7_PERIOD = 127;

endpackage : prbs_pkg

// File: rtl/prbs_err_window.sv
// Sliding error-density monitor: counts errors per WINDOW-bit window while enabled
// and flags loss when the count would reach LOSS_THRESH on the current bit.
module prbs_err_window #(
  parameter int unsigned WINDOW      = 32,
  parameter int unsigned LOSS_THRESH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic err,
  input  logic restart,
  output logic loss
);

  localparam int unsigned WC_W = $clog2(WINDOW + 1);
  localparam int unsigned WE_W = $clog2(LOSS_THRESH + 1);

  logic [WC_W-1:0] r_win_cnt;
  logic [WE_W-1:0] r_win_err;
  logic            w_wrap;
  logic [WE_W-1:0] w_base;
  logic [WE_W-1:0] w_err_nxt;

  // The bit on the wrap edge is the first bit of the new window.
  always_comb begin
    w_wrap    = (r_win_cnt == WC_W'(WINDOW - 1));
    w_base    = w_wrap ? '0 : r_win_err;
    w_err_nxt = w_base + WE_W'(err);
    loss      = enable && err && (w_err_nxt >= WE_W'(LOSS_THRESH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win_cnt <= '0;
      r_win_err <= '0;
    end else if (!enable || restart) begin
      r_win_cnt <= '0;
      r_win_err <= '0;
    end else begin
      r_win_cnt <= w_wrap ? '0 : r_win_cnt + WC_W'(1);
      r_win_err <= w_err_nxt;
    end
  end

endmodule : prbs_err_window

// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises to a Fibonacci PRBS stream, declares lock,
// then counts bit errors and drops lock on excessive error density.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned WIDTH       = PRBS7_WIDTH,
  parameter int unsigned TAP         = PRBS7_TAP,
  parameter int unsigned SYNC_LEN    = 16,
  parameter int unsigned WINDOW      = 32,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IN,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W = $clog2(SYNC_LEN + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_hist;
  logic [WIDTH-1:0]   w_hist_nxt;
  logic [FILL_W-1:0]  r_fill_cnt;
  logic [FILL_W-1:0]  w_fill_nxt;
  logic [MATCH_W-1:0] r_match_cnt;
  logic [MATCH_W-1:0] w_match_nxt;
  logic               w_pred;
  logic               w_err_lock;
  logic               w_loss;
  logic               w_is_locked;
  logic               r_err_pulse;
  logic [CNT_W-1:0]   r_err_count;
  logic [CNT_W-1:0]   r_bit_count;

  assign w_pred      = r_hist[WIDTH-1] ^ r_hist[TAP-1];
  assign w_is_locked = (r_state == LOCKED);

  prbs_err_window #(
    .WINDOW      (WINDOW),
    .LOSS_THRESH (LOSS_THRESH)
  ) u_err_window (
    .clk     (clk),
    .reset   (reset),
    .enable  (w_is_locked),
    .err     (w_err_lock),
    .restart (w_loss),
    .loss    (w_loss)
  );

  // Next-state logic; once locked the history free-runs on its own prediction.
  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill_cnt;
    w_match_nxt = r_match_cnt;
    w_err_lock  = 1'b0;
    case (r_state)
      SEARCH: begin
        w_hist_nxt = {r_hist[WIDTH-2:0], IN};
        if (r_fill_cnt < FILL_W'(WIDTH)) begin
          w_fill_nxt = r_fill_cnt + FILL_W'(1);
        end else if ((IN == w_pred) && (r_hist != '0)) begin
          if (r_match_cnt == MATCH_W'(SYNC_LEN - 1)) begin
            w_state_nxt = LOCKED;
            w_match_nxt = '0;
          end else begin
            w_match_nxt = r_match_cnt + MATCH_W'(1);
          end
        end else begin
          w_match_nxt = '0;
        end
      end
      LOCKED: begin
        w_hist_nxt = {r_hist[WIDTH-2:0], w_pred};
        w_err_lock = IN ^ w_pred;
        if (w_loss) begin
          w_state_nxt = SEARCH;
          w_fill_nxt  = '0;
          w_match_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= SEARCH;
      r_hist      <= '0;
      r_fill_cnt  <= '0;
      r_match_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hist      <= w_hist_nxt;
      r_fill_cnt  <= w_fill_nxt;
      r_match_cnt <= w_match_nxt;
    end
  end

  // Saturating statistics; clear takes priority over a same-edge increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
      r_bit_count <= '0;
    end else begin
      r_err_pulse <= w_err_lock;
      if (clear) begin
        r_err_count <= '0;
        r_bit_count <= '0;
      end else if (w_is_locked) begin
        if (r_bit_count != '1) begin
          r_bit_count <= r_bit_count + CNT_W'(1);
        end
        if (w_err_lock && (r_err_count != '1)) begin
          r_err_count <= r_err_count + CNT_W'(1);
        end
      end
    end
  end

  assign locked    = w_is_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign bit_count = r_bit_count;

endmodule : prbs_checker

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a queue-based reference model predicts every
// cycle's outputs; a monitor compares them against the DUT after each clock edge.
module tb_prbs_checker;

  localparam int W    = 7;
  localparam int TAP  = 6;
  localparam int SYNC = 16;
  localparam int WIN  = 32;
  localparam int THR  = 4;
  localparam int CW   = 16;
  localparam int SAT  = (1 << CW) - 1;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          IN    = 1'b0;
  logic          clear = 1'b0;
  logic          locked;
  logic          err_pulse;
  logic [CW-1:0] err_count;
  logic [CW-1:0] bit_count;

  prbs_checker #(
    .WIDTH       (W),
    .TAP         (TAP),
    .SYNC_LEN    (SYNC),
    .WINDOW      (WIN),
    .LOSS_THRESH (THR),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .IN        (IN),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit lk;
    bit pl;
    int ec;
    int bc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Clean PRBS-7 source, seeded with seven ones.
  bit gen_q[$];
  function automatic bit next_clean();
    bit b;
    if (gen_q.size() < W) b = 1'b1;
    else b = gen_q[gen_q.size()-W] ^ gen_q[gen_q.size()-TAP];
    gen_q.push_back(b);
    if (gen_q.size() > 2*W) void'(gen_q.pop_front());
    return b;
  endfunction

  // Reference model state.
  bit m_locked;
  bit m_hist[$];
  int m_since, m_run, m_p, m_win_id, m_win_errs, m_errc, m_bitc;

  function automatic void model_reset();
    m_locked = 0; m_hist.delete();
    m_since = 0; m_run = 0; m_p = 0; m_win_id = 0; m_win_errs = 0;
    m_errc = 0; m_bitc = 0;
  endfunction

  function automatic void model_step(bit b, bit c);
    bit pulse = 0;
    bit pred;
    bit nz;
    exp_t e;
    if (!m_locked) begin
      if (m_since >= W) begin
        pred = m_hist[m_hist.size()-W] ^ m_hist[m_hist.size()-TAP];
        nz = 0;
        for (int k = 1; k <= W; k++) nz |= m_hist[m_hist.size()-k];
        if (b == pred && nz) m_run++;
        else m_run = 0;
        if (m_run == SYNC) begin
          m_locked = 1; m_p = 0; m_win_id = 0; m_win_errs = 0;
        end
      end
      m_since++;
      m_hist.push_back(b);
    end else begin
      pred = m_hist[m_hist.size()-W] ^ m_hist[m_hist.size()-TAP];
      m_hist.push_back(pred);
      if (m_bitc < SAT) m_bitc++;
      if (b != pred) begin
        pulse = 1;
        if (m_errc < SAT) m_errc++;
      end
      if ((m_p + 1) / WIN != m_win_id) begin
        m_win_id   = (m_p + 1) / WIN;
        m_win_errs = 0;
      end
      if (b != pred) m_win_errs++;
      m_p++;
      if (m_win_errs >= THR) begin
        m_locked = 0; m_since = 0; m_run = 0;
      end
    end
    if (c) begin
      m_errc = 0; m_bitc = 0;
    end
    while (m_hist.size() > W) void'(m_hist.pop_front());
    e.lk = m_locked; e.pl = pulse; e.ec = m_errc; e.bc = m_bitc;
    exp_q.push_back(e);
  endfunction

  task automatic apply(input bit b, input bit c);
    IN    = b;
    clear = c;
    model_step(b, c);
  endtask

  task automatic step(input bit b, input bit c);
    @(negedge clk);
    apply(b, c);
  endtask

  task automatic clean_bits(input int n);
    for (int i = 0; i < n; i++) step(next_clean(), 1'b0);
  endtask

  // Feed clean bits until the model's next locked bit has index p since lock.
  task automatic advance_to(input int p);
    int guard = 0;
    while (!(m_locked && m_p == p)) begin
      step(next_clean(), 1'b0);
      guard++;
      if (guard > 2000) begin
        n_checks++;
        n_fail++;
        $display("FAIL advance_to: bound expired waiting for bit %0d after lock", p);
        break;
      end
    end
  endtask

  task automatic inject(input bit c);
    step(~next_clean(), c);
  endtask

  // Monitor: one expected record per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("locked",    longint'(locked),    longint'(e.lk));
        check("err_pulse", longint'(err_pulse), longint'(e.pl));
        check("err_count", longint'(err_count), longint'(e.ec));
        check("bit_count", longint'(bit_count), longint'(e.bc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int err_pos[$] = '{70, 75, 80, 95, 100, 105, 130, 131, 133, 135};

  initial begin
    model_reset();
    #7;
    check("rst_locked",    longint'(locked),    0);
    check("rst_err_pulse", longint'(err_pulse), 0);
    check("rst_err_count", longint'(err_count), 0);
    check("rst_bit_count", longint'(bit_count), 0);

    @(negedge clk);
    reset = 1'b1;
    apply(next_clean(), 1'b0);

    // Single error, then three errors in each of two windows (one on the wrap bit),
    // then four errors in one window.
    advance_to(50);
    inject(1'b0);
    foreach (err_pos[i]) begin
      advance_to(err_pos[i]);
      inject(1'b0);
    end
    clean_bits(40);

    // Clear on the same edge as an error.
    advance_to(20);
    inject(1'b1);
    clean_bits(30);

    // Asynchronous reset while locked.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_locked",    longint'(locked),    0);
    check("midrst_err_pulse", longint'(err_pulse), 0);
    check("midrst_err_count", longint'(err_count), 0);
    check("midrst_bit_count", longint'(bit_count), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    apply(next_clean(), 1'b0);
    clean_bits(60);

    // Randomised errors and clears.
    for (int i = 0; i < 800; i++) begin
      bit b;
      bit c;
      b = next_clean();
      if ($urandom_range(0, 47) == 0) b = ~b;
      c = ($urandom_range(0, 199) == 0);
      step(b, c);
    end

    // Degenerate constant inputs must never lock.
    for (int i = 0; i < 500; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 500; i++) step(1'b1, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", longint'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_prbs_checker
